upsampler_h_window_gen_fp16: RTL and testbench

Horizontal 2x zero-insertion window generator for the FP16 upsampler path. Accepts one FP16 pixel per handshake, inserts a zero after every pixel, and presents a 1x4 sliding window with matching col/row/valid. The outputs feed the 4-tap horizontal upsampling convolution (kernel 0.25/0.75/0.75/0.25) directly, so each output column is one interpolated sample. Input is back-pressured because the output rate is twice the input rate.

---
 rtl/upsampler_h_window_gen_fp16_if.sv | 25 ++
 rtl/upsampler_h_window_gen_fp16.sv | 107 ++++++++++
 tb/tb_upsampler_h_window_gen_fp16.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/upsampler_h_window_gen_fp16_if.sv
// Pixel-in / window-out bundle for the horizontal 2x zero-insertion window generator.
// The slave modport is the generator's side; the master modport is the upstream/downstream side.
interface upsampler_h_window_gen_fp16_if #(
  parameter int FP_WIDTH_REG = 16
);
  logic [FP_WIDTH_REG-1:0]            data_i;
  logic [15:0]                        col_i;
  logic [15:0]                        row_i;
  logic                               valid_i;
  logic                               ready_o;
  logic [0:0][3:0][FP_WIDTH_REG-1:0]  window_o;
  logic [15:0]                        col_o;
  logic [15:0]                        row_o;
  logic                               valid_o;

  modport slave (
    input  data_i, col_i, row_i, valid_i,
    output ready_o, window_o, col_o, row_o, valid_o
  );

  modport master (
    output data_i, col_i, row_i, valid_i,
    input  ready_o, window_o, col_o, row_o, valid_o
  );
endinterface

// File: rtl/upsampler_h_window_gen_fp16.sv
// Horizontal 2x zero-insertion window generator: each accepted pixel is followed by a zero
// sample, and a 1x4 sliding window over the upsampled stream is emitted per output column.
module upsampler_h_window_gen_fp16 #(
  parameter int EXP_WIDTH    = 5,
  parameter int FRAC_WIDTH   = 10,
  parameter int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH,
  parameter int IMG_WIDTH    = 640
) (
  input logic clk_i,
  input logic rst_i,
  upsampler_h_window_gen_fp16_if.slave bus
);

  localparam logic [15:0] LAST_COL = 16'(IMG_WIDTH - 1);

  typedef enum logic [1:0] {S_PIX, S_ZERO, S_FL0, S_FL1} state_t;

  state_t                          r_state;
  state_t                          w_stateNext;
  logic [3:0][FP_WIDTH_REG-1:0]    r_sr;
  logic [15:0]                     r_j;
  logic [15:0]                     r_col;
  logic [15:0]                     r_row;
  logic                            r_valid;
  logic                            r_lastCol;

  logic                            w_xfer;
  logic                            w_push;
  logic                            w_restart;
  logic [FP_WIDTH_REG-1:0]         w_sample;
  logic [15:0]                     w_jCur;
  logic                            w_emit;

  always_comb begin
    w_stateNext = r_state;
    w_xfer      = 1'b0;
    w_push      = 1'b0;
    w_sample    = '0;
    case (r_state)
      S_PIX: begin
        w_xfer = bus.valid_i;
        if (bus.valid_i) begin
          w_push      = 1'b1;
          w_sample    = bus.data_i;
          w_stateNext = S_ZERO;
        end
      end
      S_ZERO: begin
        w_push      = 1'b1;
        w_stateNext = r_lastCol ? S_FL0 : S_PIX;
      end
      S_FL0: begin
        w_push      = 1'b1;
        w_stateNext = S_FL1;
      end
      S_FL1: begin
        w_push      = 1'b1;
        w_stateNext = S_PIX;
      end
      default: w_stateNext = S_PIX;
    endcase
  end

  // A column-0 pixel restarts the row, so its push is always index 0 of a cleared register.
  assign w_restart = w_xfer && (bus.col_i == 16'd0);
  assign w_jCur    = w_restart ? 16'd0 : r_j;
  assign w_emit    = w_push && (w_jCur >= 16'd2);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_PIX;
      r_sr      <= '0;
      r_j       <= 16'd0;
      r_col     <= 16'd0;
      r_row     <= 16'd0;
      r_valid   <= 1'b0;
      r_lastCol <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_valid <= w_emit;
      if (w_push) begin
        if (w_restart) begin
          r_sr <= {w_sample, {(3*FP_WIDTH_REG){1'b0}}};
        end else begin
          r_sr <= {w_sample, r_sr[3:1]};
        end
        r_j <= (r_state == S_FL1) ? 16'd0 : w_jCur + 16'd1;
      end
      if (w_emit) begin
        r_col <= w_jCur - 16'd2;
      end
      if (w_restart) begin
        r_row <= bus.row_i;
      end
      if (w_xfer) begin
        r_lastCol <= (bus.col_i == LAST_COL);
      end
    end
  end

  assign bus.ready_o     = (r_state == S_PIX) && !rst_i;
  assign bus.window_o[0] = r_sr;
  assign bus.col_o       = r_col;
  assign bus.row_o       = r_row;
  assign bus.valid_o     = r_valid;

endmodule

// File: tb/tb_upsampler_h_window_gen_fp16.sv
// Scoreboard bench for upsampler_h_window_gen_fp16 with a 4-pixel row: expected windows are
// built from the zero-inserted stream when pixels are driven and matched as valid_o strobes.
module tb_upsampler_h_window_gen_fp16;

  localparam int IMG_W = 4;
  localparam int FPW   = 16;

  typedef struct {
    logic [15:0] col;
    logic [15:0] row;
    logic [63:0] win;
  } exp_t;

  logic clk;
  logic rst;
  int   assertCount;
  int   failCount;
  exp_t expQ[$];

  upsampler_h_window_gen_fp16_if #(.FP_WIDTH_REG(FPW)) bus ();

  upsampler_h_window_gen_fp16 #(
    .EXP_WIDTH(5),
    .FRAC_WIDTH(10),
    .FP_WIDTH_REG(FPW),
    .IMG_WIDTH(IMG_W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    assertCount++;
    if (got !== want) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] uVal(input int j, input logic [3:0][15:0] pix);
    if (j < 0 || j >= 2 * IMG_W || (j % 2) != 0) return 16'h0000;
    return pix[j / 2];
  endfunction

  task automatic expectRow(input logic [15:0] row, input logic [3:0][15:0] pix, input int nCols);
    exp_t e;
    for (int c = 0; c < nCols; c++) begin
      e.col = 16'(c);
      e.row = row;
      e.win = {uVal(c + 2, pix), uVal(c + 1, pix), uVal(c, pix), uVal(c - 1, pix)};
      expQ.push_back(e);
    end
  endtask

  // Returns at the falling edge just after the transfer edge, with valid_i dropped.
  task automatic applyStimulus(input logic [15:0] data, input logic [15:0] col,
                               input logic [15:0] row, input int gap);
    int guard;
    for (int g = 0; g < gap; g++) begin
      bus.valid_i = 1'b0;
      @(negedge clk);
    end
    bus.data_i  = data;
    bus.col_i   = col;
    bus.row_i   = row;
    bus.valid_i = 1'b1;
    guard = 0;
    while (!bus.ready_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("readyTimeout", 64'd0, 64'd1);
    @(negedge clk);
    bus.valid_i = 1'b0;
    checkOutput("readyAfterXfer", 64'(bus.ready_o), 64'd0);
  endtask

  task automatic sendRow(input logic [15:0] row, input logic [3:0][15:0] pix,
                         input int nPix, input int gap);
    for (int k = 0; k < nPix; k++) begin
      applyStimulus(pix[k], 16'(k), row, gap);
    end
  endtask

  task automatic drain(input string tag);
    repeat (6) @(negedge clk);
    checkOutput(tag, 64'(expQ.size()), 64'd0);
    expQ.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.valid_o === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedValid", {48'd0, bus.col_o}, 64'hFFFF);
      end else begin
        e = expQ.pop_front();
        checkOutput("col", 64'(bus.col_o), 64'(e.col));
        checkOutput("row", 64'(bus.row_o), 64'(e.row));
        checkOutput("window", bus.window_o[0], e.win);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0][15:0] pixA;
    logic [3:0][15:0] pixOnes;
    logic [3:0][15:0] pixTwos;
    logic [3:0][15:0] pixB;
    assertCount = 0;
    failCount   = 0;
    pixA    = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
    pixOnes = {4{16'h3C00}};
    pixTwos = {4{16'h4000}};
    pixB    = {16'hC500, 16'h4A00, 16'h4800, 16'h3800};

    bus.data_i  = 16'h1234;
    bus.col_i   = 16'd0;
    bus.row_i   = 16'd9;
    bus.valid_i = 1'b1;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("rstReady", 64'(bus.ready_o), 64'd0);
      checkOutput("rstValid", 64'(bus.valid_o), 64'd0);
      checkOutput("rstWindow", bus.window_o[0], 64'd0);
      checkOutput("rstColRow", {32'd0, bus.col_o, bus.row_o}, 64'd0);
    end
    bus.valid_i = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("readyAfterRst", 64'(bus.ready_o), 64'd1);

    // Back-to-back row, including the flush-cycle ready pattern.
    expectRow(16'd5, pixA, 2 * IMG_W);
    sendRow(16'd5, pixA, IMG_W, 0);
    @(negedge clk);
    checkOutput("readyFl0", 64'(bus.ready_o), 64'd0);
    @(negedge clk);
    checkOutput("readyFl1", 64'(bus.ready_o), 64'd0);
    @(negedge clk);
    checkOutput("readyNextRow", 64'(bus.ready_o), 64'd1);
    drain("drainBackToBack");

    expectRow(16'd5, pixA, 2 * IMG_W);
    sendRow(16'd5, pixA, IMG_W, 4);
    drain("drainGapped");

    expectRow(16'd0, pixOnes, 2 * IMG_W);
    expectRow(16'd1, pixTwos, 2 * IMG_W);
    sendRow(16'd0, pixOnes, IMG_W, 0);
    sendRow(16'd1, pixTwos, IMG_W, 0);
    drain("drainTwoRows");

    // Two pixels of row 2, then a column-0 pixel abandons it.
    expectRow(16'd2, pixB, 2);
    expectRow(16'd3, pixA, 2 * IMG_W);
    sendRow(16'd2, pixB, 2, 0);
    sendRow(16'd3, pixA, IMG_W, 0);
    drain("drainRestart");

    // Reset lands while the generator is in its first flush state.
    expectRow(16'd7, pixB, 6);
    sendRow(16'd7, pixB, IMG_W, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("midRstWindow", bus.window_o[0], 64'd0);
    rst = 1'b0;
    expectRow(16'd8, pixOnes, 2 * IMG_W);
    sendRow(16'd8, pixOnes, IMG_W, 1);
    drain("drainAfterMidRst");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
